// File: rtl/vcve2_vlsu_pkg.sv
// Shared state encoding, element-width codes and byte-enable helper for the
// vector unit-stride load/store sequencer.
package vcve2_vlsu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      REQ,
      WAIT,
      DONE
   } vlsu_state_e;

   localparam logic [1:0] EEW_8   = 2'd0;
   localparam logic [1:0] EEW_16  = 2'd1;
   localparam logic [1:0] EEW_32  = 2'd2;
   localparam logic [1:0] EEW_ILL = 2'd3;

   localparam logic [3:0] BE_FULL = 4'b1111;

   // Byte enable of the final word, from the low two bits of the byte count.
   function automatic logic [3:0] last_be(input logic [1:0] tail);
      logic [3:0] be;
      if (tail == 2'd0) begin
         be = BE_FULL;
      end else begin
         be = (4'b0001 << tail) - 4'b0001;
      end
      return be;
   endfunction

endpackage

// File: rtl/vcve2_vlsu_wcalc.sv
// Combinational word count and final-word byte enable for one vector
// memory instruction, derived from vl and the element width.
module vcve2_vlsu_wcalc
   import vcve2_vlsu_pkg::*;
#(
   parameter int VL_W      = 8,
   parameter int MAX_WORDS = 4,
   parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic [VL_W-1:0]  vl_i,
   input  logic [1:0]       eew_i,
   output logic [CNT_W-1:0] nwords_o,
   output logic [3:0]       last_be_o
);

   logic [VL_W+1:0] bytes;
   logic [VL_W-1:0] words;

   always_comb begin
      bytes = '0;
      unique case (eew_i)
         EEW_8:   bytes = {2'b00, vl_i};
         EEW_16:  bytes = {1'b0, vl_i, 1'b0};
         EEW_32:  bytes = {vl_i, 2'b00};
         EEW_ILL: bytes = '0;
      endcase
      words = bytes[VL_W+1:2] + VL_W'(|bytes[1:0]);
      // A saturated instruction fills every word of the register.
      if (words > VL_W'(MAX_WORDS)) begin
         nwords_o  = CNT_W'(MAX_WORDS);
         last_be_o = BE_FULL;
      end else begin
         nwords_o  = CNT_W'(words);
         last_be_o = last_be(bytes[1:0]);
      end
   end

endmodule

// File: rtl/vcve2_vlsu_sequencer.sv
// Word sequencer turning one unit-stride vector load/store into 32-bit LSU
// transactions, one outstanding. VCVE2_VLSU_ERR_EN adds lsu_err_i / err_o.
module vcve2_vlsu_sequencer
   import vcve2_vlsu_pkg::*;
#(
   parameter int VRF_AW    = 7,
   parameter int MAX_WORDS = 4,
   parameter int VL_W      = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              is_store_i,
   input  logic [4:0]        vreg_i,
   input  logic [1:0]        eew_i,
   input  logic [VL_W-1:0]   vl_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              load_start_o,
   output logic              vec_op_o,
   output logic              vrf_req_o,
   output logic [3:0]        vrf_lsu_be_o,
   output logic [31:0]       vrf_data_o,
   input  logic              lsu_gnt_i,
   input  logic              lsu_rvalid_i,
   input  logic [31:0]       lsu_rdata_i,
   output logic [VRF_AW-1:0] vrf_raddr_o,
   output logic              vrf_re_o,
   input  logic [31:0]       vrf_rdata_i,
   output logic [VRF_AW-1:0] vrf_waddr_o,
   output logic              vrf_we_o,
   output logic [3:0]        vrf_wbe_o,
   output logic [31:0]       vrf_wdata_o
`ifdef VCVE2_VLSU_ERR_EN
   ,
   input  logic              lsu_err_i,
   output logic              err_o
`endif
);

   localparam int IDX_W = $clog2(MAX_WORDS);
   localparam int CNT_W = $clog2(MAX_WORDS + 1);

   vlsu_state_e       state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d, last_idx_q, last_idx_d;
   logic [4:0]        vreg_q, vreg_d;
   logic              store_q, store_d;
   logic [3:0]        last_be_q, last_be_d;
   logic [31:0]       data_q, data_d;
   logic              cap_q, cap_d;
   logic              rsp_q, rsp_d;
   logic              we_q, we_d;
   logic [VRF_AW-1:0] waddr_q, waddr_d;
   logic [3:0]        wbe_q, wbe_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [CNT_W-1:0]  nwords;
   logic [3:0]        calc_be, word_be;
   logic              resp_err;
`ifdef VCVE2_VLSU_ERR_EN
   logic              err_q, err_d, rerr_q, rerr_d;

   assign resp_err = rsp_q ? rerr_q : lsu_err_i;
`else
   assign resp_err = 1'b0;
`endif

   vcve2_vlsu_wcalc #(
      .VL_W      (VL_W),
      .MAX_WORDS (MAX_WORDS),
      .CNT_W     (CNT_W)
   ) u_wcalc (
      .vl_i      (vl_i),
      .eew_i     (eew_i),
      .nwords_o  (nwords),
      .last_be_o (calc_be)
   );

   assign word_be     = (idx_q == last_idx_q) ? last_be_q : BE_FULL;
   assign busy_o      = (state_q != IDLE);
   assign vec_op_o    = busy_o;
   assign vrf_we_o    = we_q;
   assign vrf_waddr_o = waddr_q;
   assign vrf_wbe_o   = wbe_q;
   assign vrf_wdata_o = wdata_q;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      last_idx_d   = last_idx_q;
      vreg_d       = vreg_q;
      store_d      = store_q;
      last_be_d    = last_be_q;
      data_d       = data_q;
      cap_d        = cap_q;
      rsp_d        = rsp_q;
      we_d         = 1'b0;
      waddr_d      = waddr_q;
      wbe_d        = wbe_q;
      wdata_d      = wdata_q;
      load_start_o = 1'b0;
      done_o       = 1'b0;
      vrf_req_o    = 1'b0;
      vrf_lsu_be_o = '0;
      vrf_data_o   = '0;
      vrf_re_o     = 1'b0;
      vrf_raddr_o  = '0;
`ifdef VCVE2_VLSU_ERR_EN
      err_d        = err_q;
      rerr_d       = rerr_q;
      err_o        = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               if (nwords == '0) begin
                  state_d = DONE;
`ifdef VCVE2_VLSU_ERR_EN
                  err_d = (eew_i == EEW_ILL);
`endif
               end else begin
                  load_start_o = 1'b1;
                  vreg_d       = vreg_i;
                  store_d      = is_store_i;
                  last_idx_d   = IDX_W'(nwords - CNT_W'(1));
                  last_be_d    = calc_be;
                  idx_d        = '0;
                  state_d      = is_store_i ? FETCH : REQ;
               end
            end
         end
         FETCH: begin
            vrf_re_o    = 1'b1;
            vrf_raddr_o = VRF_AW'({vreg_q, idx_q});
            cap_d       = 1'b1;
            state_d     = REQ;
         end
         REQ: begin
            vrf_req_o    = 1'b1;
            vrf_lsu_be_o = word_be;
            // The VRF read lands during the first REQ cycle; forward it until held.
            vrf_data_o   = cap_q ? vrf_rdata_i : data_q;
            if (cap_q) begin
               data_d = vrf_rdata_i;
               cap_d  = 1'b0;
            end
            if (lsu_gnt_i) begin
               state_d = WAIT;
               if (lsu_rvalid_i) begin
                  rsp_d   = 1'b1;
                  wdata_d = lsu_rdata_i;
`ifdef VCVE2_VLSU_ERR_EN
                  rerr_d  = lsu_err_i;
`endif
               end
            end
         end
         WAIT: begin
            if (lsu_rvalid_i || rsp_q) begin
               rsp_d = 1'b0;
               if (resp_err) begin
                  state_d = DONE;
`ifdef VCVE2_VLSU_ERR_EN
                  err_d   = 1'b1;
`endif
               end else begin
                  if (!store_q) begin
                     we_d    = 1'b1;
                     waddr_d = VRF_AW'({vreg_q, idx_q});
                     wbe_d   = word_be;
                     if (!rsp_q) begin
                        wdata_d = lsu_rdata_i;
                     end
                  end
                  if (idx_q == last_idx_q) begin
                     state_d = DONE;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     state_d = store_q ? FETCH : REQ;
                  end
               end
            end
         end
         DONE: begin
            // Hold off completion until the final VRF write has been presented.
            if (!we_q) begin
               done_o  = 1'b1;
               state_d = IDLE;
`ifdef VCVE2_VLSU_ERR_EN
               err_o   = err_q;
               err_d   = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         last_idx_q <= '0;
         vreg_q     <= '0;
         store_q    <= 1'b0;
         last_be_q  <= '0;
         data_q     <= '0;
         cap_q      <= 1'b0;
         rsp_q      <= 1'b0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wbe_q      <= '0;
         wdata_q    <= '0;
`ifdef VCVE2_VLSU_ERR_EN
         err_q      <= 1'b0;
         rerr_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         last_idx_q <= last_idx_d;
         vreg_q     <= vreg_d;
         store_q    <= store_d;
         last_be_q  <= last_be_d;
         data_q     <= data_d;
         cap_q      <= cap_d;
         rsp_q      <= rsp_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wbe_q      <= wbe_d;
         wdata_q    <= wdata_d;
`ifdef VCVE2_VLSU_ERR_EN
         err_q      <= err_d;
         rerr_q     <= rerr_d;
`endif
      end
   end

endmodule

// File: tb/tb_vcve2_vlsu_sequencer.sv
// Directed and randomized bench for vcve2_vlsu_sequencer: an LSU responder with
// programmable grant/response delays, a VRF read model and a word-level model.
module tb_vcve2_vlsu_sequencer;

   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        is_store = 1'b0;
   logic [4:0]  vreg = '0;
   logic [1:0]  eew = '0;
   logic [7:0]  vl_in = '0;
   logic        busy_o, done_o, load_start_o, vec_op_o, vrf_req_o, vrf_re_o, vrf_we_o;
   logic [3:0]  vrf_lsu_be_o, vrf_wbe_o;
   logic [31:0] vrf_data_o, vrf_wdata_o;
   logic [6:0]  vrf_raddr_o, vrf_waddr_o;
   logic        lsu_gnt, lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic [31:0] vrf_rdata = '0;
`ifdef VCVE2_VLSU_ERR_EN
   logic        lsu_err, err_o;
   int          err_cnt = 0;
`endif

   logic [31:0] mem [0:127];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_err = 0;

   // responder / monitor state
   int gnt_dly = 0, rv_dly = 0, req_wait = 0, rcnt = 0;
   bit rsp_wait = 0, in_req = 0;
   int ls_cnt = 0, done_cnt = 0, done_cyc = 0, grant_cnt = 0, rsp_total = 0, rsp_word = 0;
   int unstable = 0, vmis = 0, err_word = -1;
   logic [31:0] resp_base = '0;
   logic [3:0]  snap_be;
   logic [31:0] snap_data;
   logic [6:0]  we_addr_q [$];
   logic [3:0]  we_be_q [$];
   logic [31:0] we_data_q [$];
   int          we_cyc_q [$];
   logic [3:0]  rq_be_q [$];
   logic [31:0] rq_data_q [$];

   vcve2_vlsu_sequencer dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .is_store_i   (is_store),
      .vreg_i       (vreg),
      .eew_i        (eew),
      .vl_i         (vl_in),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .load_start_o (load_start_o),
      .vec_op_o     (vec_op_o),
      .vrf_req_o    (vrf_req_o),
      .vrf_lsu_be_o (vrf_lsu_be_o),
      .vrf_data_o   (vrf_data_o),
      .lsu_gnt_i    (lsu_gnt),
      .lsu_rvalid_i (lsu_rvalid),
      .lsu_rdata_i  (lsu_rdata),
      .vrf_raddr_o  (vrf_raddr_o),
      .vrf_re_o     (vrf_re_o),
      .vrf_rdata_i  (vrf_rdata),
      .vrf_waddr_o  (vrf_waddr_o),
      .vrf_we_o     (vrf_we_o),
      .vrf_wbe_o    (vrf_wbe_o),
      .vrf_wdata_o  (vrf_wdata_o)
`ifdef VCVE2_VLSU_ERR_EN
      ,
      .lsu_err_i    (lsu_err),
      .err_o        (err_o)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (vrf_re_o) vrf_rdata <= mem[vrf_raddr_o];

   // Reference: effective byte count, words and per-word enables from vl/eew.
   function automatic int eff_bytes(input int vl, input int ew);
      int b;
      if (ew == 3) return 0;
      b = vl * (1 << ew);
      if (b > 4 * MAXW) b = 4 * MAXW;
      return b;
   endfunction

   function automatic int exp_nwords(input int vl, input int ew);
      return (eff_bytes(vl, ew) + 3) / 4;
   endfunction

   function automatic logic [3:0] exp_be(input int vl, input int ew, input int i);
      int rem;
      rem = eff_bytes(vl, ew) - 4 * i;
      if (rem >= 4) return 4'hF;
      return 4'((1 << rem) - 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic give_rsp();
      lsu_rvalid = 1'b1;
      lsu_rdata  = resp_base + 32'(rsp_total);
`ifdef VCVE2_VLSU_ERR_EN
      lsu_err    = (rsp_word == err_word);
`endif
      rsp_total++;
      rsp_word++;
   endtask

   // LSU responder and output monitor, sampling on the falling edge.
   initial begin
      lsu_gnt = 1'b0; lsu_rvalid = 1'b0; lsu_rdata = '0;
`ifdef VCVE2_VLSU_ERR_EN
      lsu_err = 1'b0;
`endif
      forever begin
         @(negedge clk);
         lsu_gnt = 1'b0; lsu_rvalid = 1'b0;
`ifdef VCVE2_VLSU_ERR_EN
         lsu_err = 1'b0;
         if (err_o) err_cnt++;
`endif
         if (rst) begin
            rsp_wait = 0; in_req = 0;
         end else begin
            if (load_start_o) begin ls_cnt++; rsp_word = 0; end
            if (done_o) begin done_cnt++; done_cyc = cyc; end
            if (vrf_we_o) begin
               we_addr_q.push_back(vrf_waddr_o); we_be_q.push_back(vrf_wbe_o);
               we_data_q.push_back(vrf_wdata_o); we_cyc_q.push_back(cyc);
            end
            if (vec_op_o !== busy_o) vmis++;
            if (rsp_wait) begin
               rcnt++;
               if (rcnt >= rv_dly) begin give_rsp(); rsp_wait = 0; end
            end else if (vrf_req_o) begin
               if (!in_req) begin
                  snap_be = vrf_lsu_be_o; snap_data = vrf_data_o; in_req = 1; req_wait = 0;
               end else if (snap_be !== vrf_lsu_be_o || snap_data !== vrf_data_o) begin
                  unstable++;
               end
               if (req_wait >= gnt_dly) begin
                  lsu_gnt = 1'b1; in_req = 0; grant_cnt++;
                  rq_be_q.push_back(vrf_lsu_be_o); rq_data_q.push_back(vrf_data_o);
                  if (rv_dly == 0) give_rsp();
                  else begin rsp_wait = 1; rcnt = 0; end
               end else begin
                  req_wait++;
               end
            end
         end
      end
   end

   task automatic run_op(input string tag, input bit st, input logic [4:0] vr, input logic [1:0] ew,
                         input logic [7:0] vl, input int gd, input int rd);
      int nw, ls0, dn0, g0, w0, q0, r0, u0, s_cyc, t, nwr;
      nw = exp_nwords(int'(vl), int'(ew));
      gnt_dly = gd; rv_dly = rd;
      ls0 = ls_cnt; dn0 = done_cnt; g0 = grant_cnt; w0 = we_addr_q.size();
      q0 = rq_be_q.size(); r0 = rsp_total; u0 = unstable;
      @(posedge clk); #1;
      start = 1'b1; is_store = st; vreg = vr; eew = ew; vl_in = vl; s_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      t = 0;
      while (done_cnt == dn0 && t < 400) begin @(posedge clk); #2; t++; end
      chk({tag, "/done_seen"}, 32'(done_cnt > dn0), 32'd1);
      repeat (2) @(posedge clk);
      #2;
      chk({tag, "/load_start"}, 32'(ls_cnt - ls0), 32'(nw > 0));
      chk({tag, "/done_cnt"}, 32'(done_cnt - dn0), 32'd1);
      chk({tag, "/requests"}, 32'(grant_cnt - g0), 32'(nw));
      chk({tag, "/busy_idle"}, 32'(busy_o), 32'd0);
      nwr = we_addr_q.size() - w0;
      if (st || nw == 0) begin
         chk({tag, "/no_writes"}, 32'(nwr), 32'd0);
      end
      if (st && rq_be_q.size() - q0 == nw) begin
         for (int i = 0; i < nw; i++) begin
            chk($sformatf("%s/st_be%0d", tag, i), 32'(rq_be_q[q0+i]), 32'(exp_be(int'(vl), int'(ew), i)));
            chk($sformatf("%s/st_data%0d", tag, i), rq_data_q[q0+i], mem[int'(vr)*4+i]);
         end
         chk({tag, "/hold_stable"}, 32'(unstable - u0), 32'd0);
      end
      if (!st && nw > 0) begin
         chk({tag, "/writes"}, 32'(nwr), 32'(nw));
         if (nwr == nw) begin
            for (int i = 0; i < nw; i++) begin
               chk($sformatf("%s/waddr%0d", tag, i), 32'(we_addr_q[w0+i]), 32'(int'(vr)*4+i));
               chk($sformatf("%s/wbe%0d", tag, i), 32'(we_be_q[w0+i]), 32'(exp_be(int'(vl), int'(ew), i)));
               chk($sformatf("%s/wdata%0d", tag, i), we_data_q[w0+i], resp_base + 32'(r0 + i));
            end
            chk({tag, "/done_after_we"}, 32'(done_cyc), 32'(we_cyc_q[w0+nw-1] + 1));
         end
      end
      if (nw == 0) begin
         chk({tag, "/done_latency"}, 32'(done_cyc), 32'(s_cyc + 1));
      end
   endtask

   initial begin
      int w0, g0, dn0, t;
      for (int i = 0; i < 128; i++) mem[i] = $urandom;
      mem[20] = 32'h11223344;
      mem[21] = 32'h55667788;

      repeat (3) @(posedge clk);
      #2;
      chk("reset/ctrl", 32'({busy_o, done_o, load_start_o, vec_op_o, vrf_req_o, vrf_lsu_be_o,
                             vrf_re_o, vrf_we_o, vrf_wbe_o}), 32'd0);
      chk("reset/data", vrf_data_o | vrf_wdata_o, 32'd0);
      chk("reset/addr", 32'({vrf_raddr_o, vrf_waddr_o}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      resp_base = 32'hA0 - 32'(rsp_total);
      run_op("load_vl8_e32", 1'b0, 5'd3, 2'd2, 8'd8, 1, 1);
      run_op("store_vl7_e8", 1'b1, 5'd5, 2'd0, 8'd7, 3, 1);
      run_op("vl0", 1'b0, 5'd1, 2'd1, 8'd0, 0, 0);
      run_op("eew3", 1'b1, 5'd2, 2'd3, 8'd5, 0, 0);

      w0 = we_addr_q.size();
      resp_base = $urandom;
      run_op("load_same_cycle", 1'b0, 5'd9, 2'd2, 8'd4, 0, 0);
      if (we_addr_q.size() - w0 == 4) begin
         for (int i = 1; i < 4; i++) begin
            chk($sformatf("same_cycle/spacing%0d", i), 32'(we_cyc_q[w0+i] - we_cyc_q[w0+i-1]), 32'd2);
         end
      end

      // reset while waiting for the response to word 2
      gnt_dly = 0; rv_dly = 3;
      dn0 = done_cnt; g0 = grant_cnt;
      @(posedge clk); #1;
      start = 1'b1; is_store = 1'b0; vreg = 5'd7; eew = 2'd2; vl_in = 8'd4;
      @(posedge clk); #1;
      start = 1'b0;
      t = 0;
      while (grant_cnt - g0 < 3 && t < 100) begin @(posedge clk); #2; t++; end
      chk("rst/reached_wait", 32'(grant_cnt - g0), 32'd3);
      rst = 1'b1;
      @(posedge clk); #2;
      chk("rst/ctrl_zero", 32'({busy_o, done_o, load_start_o, vec_op_o, vrf_req_o, vrf_lsu_be_o,
                                vrf_re_o, vrf_we_o, vrf_wbe_o}), 32'd0);
      chk("rst/data_zero", vrf_data_o | vrf_wdata_o, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst/no_done", 32'(done_cnt - dn0), 32'd0);
      run_op("after_rst_store", 1'b1, 5'd5, 2'd0, 8'd7, 1, 1);

`ifdef VCVE2_VLSU_ERR_EN
      err_word = 1; dn0 = done_cnt; g0 = grant_cnt; w0 = we_addr_q.size(); t = err_cnt;
      gnt_dly = 1; rv_dly = 1;
      @(posedge clk); #1;
      start = 1'b1; is_store = 1'b0; vreg = 5'd2; eew = 2'd2; vl_in = 8'd4;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 100 && done_cnt == dn0; k++) begin @(posedge clk); #2; end
      repeat (2) @(posedge clk);
      #2;
      chk("err/err_pulse", 32'(err_cnt - t), 32'd1);
      chk("err/done", 32'(done_cnt - dn0), 32'd1);
      chk("err/requests", 32'(grant_cnt - g0), 32'd2);
      chk("err/writes", 32'(we_addr_q.size() - w0), 32'd1);
      err_word = -1;
`endif

      for (int n = 0; n < 12; n++) begin
         resp_base = $urandom;
         run_op($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                2'($urandom_range(0, 3)), 8'($urandom_range(0, 20)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      chk("vec_op_tracks_busy", 32'(vmis), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
